// File: rtl/axi_slave_mem_pkg.sv
// Shared burst/response/state types and the per-beat address stepping helper
// used by both engines of axi_slave_mem.
package axi_slave_mem_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  // WRAP keeps the upper bits of the aligned window and steps only inside it
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [3:0] len, input burst_t burst);
    logic [31:0] step, span, mask, inc;
    step = 32'd1 << size;
    span = ({28'd0, len} + 32'd1) << size;
    mask = span - 32'd1;
    inc  = addr + step;
    case (burst)
      BURST_INCR: next_addr = inc;
      BURST_WRAP: next_addr = (addr & ~mask) | (inc & mask);
      default:    next_addr = addr;
    endcase
  endfunction

  function automatic resp_t worst(input resp_t a, input resp_t b);
    if (a > b) return a;
    return b;
  endfunction

endpackage

// File: rtl/axi_slave_mem_addr_gen.sv
// Next-beat address generator for one AXI3 burst (FIXED/INCR/WRAP).
module axi_slave_mem_addr_gen
  import axi_slave_mem_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [3:0]  len,
  input  burst_t      burst,
  output logic [31:0] addr_next
);

  assign addr_next = next_addr(addr, size, len, burst);

endmodule

// File: rtl/axi_slave_mem.sv
// AXI3 slave memory with independent single-outstanding read and write engines.
// Define AXI_SLAVE_MEM_LAST_CHK_EN to flag misplaced or missing wlast as SLVERR.
module axi_slave_mem
  import axi_slave_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 1024
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ID_W-1:0]   awid,
  input  logic [31:0]       awaddr,
  input  logic [3:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   wid,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  input  logic [3:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int TOP    = OFF + IDX_W;

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic decerr(input logic [31:0] a);
    return a[31:TOP] != '0;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return a[TOP-1:OFF];
  endfunction

  function automatic logic cmd_err(input logic [2:0] size, input logic [3:0] len, input burst_t burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    return (32'(size) > OFF) || (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

  logic unused_ok;
  assign unused_ok = ^{awlock, awcache, awprot, arlock, arcache, arprot, wlast};

  wstate_t         wstate_q, wstate_d;
  logic            awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [ID_W-1:0] awid_q, awid_d;
  logic [31:0]     waddr_q, waddr_d, waddr_next;
  logic [3:0]      wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]      wsize_q, wsize_d;
  burst_t          wburst_q, wburst_d;
  resp_t           bresp_q, bresp_d, wbeat_resp;
  logic            w_last_beat, mem_we;

  axi_slave_mem_addr_gen u_wr_addr_gen (
    .addr(waddr_q), .size(wsize_q), .len(wlen_q), .burst(wburst_q), .addr_next(waddr_next)
  );

  always_comb begin
    wstate_d    = wstate_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    awid_d      = awid_q;
    waddr_d     = waddr_q;
    wlen_d      = wlen_q;
    wsize_d     = wsize_q;
    wburst_d    = wburst_q;
    wcnt_d      = wcnt_q;
    bresp_d     = bresp_q;
    wbeat_resp  = RESP_OKAY;
    w_last_beat = (wcnt_q == wlen_q);
    mem_we      = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (awvalid && awready_q) begin
          wstate_d  = W_DATA;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          awid_d    = awid;
          waddr_d   = awaddr;
          wlen_d    = awlen;
          wsize_d   = awsize;
          wburst_d  = burst_t'(awburst);
          wcnt_d    = '0;
          bresp_d   = cmd_err(awsize, awlen, burst_t'(awburst)) ? RESP_SLVERR : RESP_OKAY;
        end
      end
      W_DATA: begin
        if (wvalid && wready_q) begin
          if (wid != awid_q) wbeat_resp = RESP_SLVERR;
`ifdef AXI_SLAVE_MEM_LAST_CHK_EN
          if (wlast != w_last_beat) wbeat_resp = RESP_SLVERR;
`endif
          // Out-of-range beats still consume a beat but never touch the array
          if (decerr(waddr_q)) wbeat_resp = RESP_DECERR;
          else mem_we = 1'b1;
          bresp_d = worst(bresp_q, wbeat_resp);
          wcnt_d  = wcnt_q + 4'd1;
          waddr_d = waddr_next;
          if (w_last_beat) begin
            wstate_d = W_RESP;
            wready_d = 1'b0;
            bvalid_d = 1'b1;
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && bready) begin
          wstate_d  = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      awid_q    <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= BURST_FIXED;
      wcnt_q    <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      awid_q    <= awid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      wcnt_q    <= wcnt_d;
      bresp_q   <= bresp_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[word_idx(waddr_q)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  rstate_t           rstate_q, rstate_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic              rerr_q, rerr_d, r_load;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [31:0]       raddr_q, raddr_d, raddr_next, r_fetch;
  logic [3:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]        rsize_q, rsize_d;
  burst_t            rburst_q, rburst_d;
  resp_t             rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  axi_slave_mem_addr_gen u_rd_addr_gen (
    .addr(raddr_q), .size(rsize_q), .len(rlen_q), .burst(rburst_q), .addr_next(raddr_next)
  );

  // The array is sampled into rdata_q on the accepting edge, so a write landing
  // on the same edge is not yet visible to the read.
  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rerr_d    = rerr_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    r_load    = 1'b0;
    r_fetch   = raddr_next;
    if (rstate_q == R_IDLE) begin
      arready_d = 1'b1;
      if (arvalid && arready_q) begin
        rstate_d  = R_DATA;
        arready_d = 1'b0;
        rvalid_d  = 1'b1;
        rid_d     = arid;
        rlen_d    = arlen;
        rsize_d   = arsize;
        rburst_d  = burst_t'(arburst);
        rcnt_d    = '0;
        rerr_d    = cmd_err(arsize, arlen, burst_t'(arburst));
        rlast_d   = (arlen == 4'd0);
        r_fetch   = araddr;
        r_load    = 1'b1;
      end
    end else if (rvalid_q && rready) begin
      if (rlast_q) begin
        rstate_d  = R_IDLE;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
        arready_d = 1'b1;
      end else begin
        rcnt_d  = rcnt_q + 4'd1;
        rlast_d = ((rcnt_q + 4'd1) == rlen_q);
        r_load  = 1'b1;
      end
    end
    if (r_load) begin
      raddr_d = r_fetch;
      if (decerr(r_fetch)) begin
        rdata_d = '0;
        rresp_d = RESP_DECERR;
      end else begin
        rdata_d = mem[word_idx(r_fetch)];
        rresp_d = rerr_d ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rerr_q    <= 1'b0;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= BURST_FIXED;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rerr_q    <= rerr_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = awid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem (DATA_W=32, ID_W=4, DEPTH=1024).
// The wlast-check test follows AXI_SLAVE_MEM_LAST_CHK_EN when it is defined.
module tb_axi_slave_mem;

  logic        aclk;
  logic        aresetn;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int          nAsserts = 0;
  int          nFails = 0;
  logic [31:0] wrData [16];
  logic [31:0] rdData [16];
  logic [1:0]  rdResp [16];
  logic        rdLast [16];
  logic [3:0]  rdId;
  int          nBeats;
  logic [1:0]  gotBresp;
  logic [3:0]  gotBid;

  axi_slave_mem #(.DATA_W(32), .ID_W(4), .DEPTH(1024)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
      else begin
        nFails++;
        $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
  endtask

  // Idle every master-side input and hold the slave in reset for a few cycles
  task automatic applyStimulus();
    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
    awlock = '0; awcache = '0; awprot = '0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0;
    arlock = '0; arcache = '0; arprot = '0; rready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
  endtask

  task automatic writeBurst(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                            input logic [3:0] strb, input logic [3:0] idAw, input logic [3:0] idW,
                            input int lastAt);
    int cyc;
    awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awid = idAw; awvalid = 1'b1;
    cyc = 0;
    while (!awready && cyc < 50) begin @(posedge aclk); #1; cyc++; end
    @(posedge aclk); #1;
    awvalid = 1'b0;
    checkOutput("awAccept", 32'(cyc < 50), 32'd1);
    checkOutput("wreadyAfterAw", 32'(wready), 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wrData[i]; wstrb = strb; wid = idW; wlast = (i == lastAt); wvalid = 1'b1;
      cyc = 0;
      while (!wready && cyc < 50) begin @(posedge aclk); #1; cyc++; end
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    checkOutput("bvalidAfterLast", 32'(bvalid), 32'd1);
    gotBresp = bresp; gotBid = bid;
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    checkOutput("awreadyAfterB", 32'(awready), 32'd1);
  endtask

  task automatic readBurst(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input logic toggle);
    int          cyc;
    logic        holdPending;
    logic [31:0] holdData;
    araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
    cyc = 0;
    while (!arready && cyc < 50) begin @(posedge aclk); #1; cyc++; end
    @(posedge aclk); #1;
    arvalid = 1'b0;
    checkOutput("arAccept", 32'(cyc < 50), 32'd1);
    checkOutput("rvalidLatency", 32'(rvalid), 32'd1);
    nBeats = 0; cyc = 0; holdPending = 1'b0; holdData = '0;
    while (nBeats <= int'(len) && cyc < 200) begin
      rready = toggle ? cyc[0] : 1'b1;
      if (rvalid && rready) begin
        rdData[nBeats] = rdata; rdResp[nBeats] = rresp; rdLast[nBeats] = rlast; rdId = rid;
        nBeats++;
      end else if (rvalid) begin
        holdPending = 1'b1; holdData = rdata;
      end
      @(posedge aclk); #1;
      cyc++;
      if (holdPending) begin
        checkOutput("rdataHold", rdata, holdData);
        holdPending = 1'b0;
      end
    end
    rready = 1'b0;
    checkOutput("rBeats", 32'(nBeats), 32'(len) + 32'd1);
    checkOutput("rvalidDrop", 32'(rvalid), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus();
    checkOutput("rstOutputs", 32'({awready, wready, bvalid, bid, bresp, arready, rvalid, rlast, rid, rresp}), 32'd0);
    checkOutput("rstRdata", rdata, 32'd0);
    aresetn = 1'b1;
    checkOutput("readyBeforeEdge", 32'({awready, arready}), 32'd0);
    @(posedge aclk); #1;
    checkOutput("readyAfterEdge", 32'({awready, arready}), 32'd3);

    // INCR write then readback
    wrData[0] = 32'h11; wrData[1] = 32'h22; wrData[2] = 32'h33; wrData[3] = 32'h44;
    writeBurst(32'h100, 4'd3, 2'b01, 4'hF, 4'd5, 4'd5, 3);
    checkOutput("incrBresp", 32'(gotBresp), 32'd0);
    checkOutput("incrBid", 32'(gotBid), 32'd5);
    readBurst(32'h100, 4'd3, 3'd2, 2'b01, 4'd9, 1'b0);
    checkOutput("incrRid", 32'(rdId), 32'd9);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("incrRdata%0d", i), rdData[i], 32'h11 * (i + 1));
      checkOutput($sformatf("incrRresp%0d", i), 32'(rdResp[i]), 32'd0);
      checkOutput($sformatf("incrRlast%0d", i), 32'(rdLast[i]), 32'(i == 3));
    end

    // WRAP write at 0x108: lands at 0x108,0x10C,0x100,0x104
    wrData[0] = 32'hA0; wrData[1] = 32'hA1; wrData[2] = 32'hA2; wrData[3] = 32'hA3;
    writeBurst(32'h108, 4'd3, 2'b10, 4'hF, 4'd1, 4'd1, 3);
    checkOutput("wrapBresp", 32'(gotBresp), 32'd0);
    readBurst(32'h100, 4'd3, 3'd2, 2'b01, 4'd2, 1'b0);
    checkOutput("wrapLin0", rdData[0], 32'hA2);
    checkOutput("wrapLin1", rdData[1], 32'hA3);
    checkOutput("wrapLin2", rdData[2], 32'hA0);
    checkOutput("wrapLin3", rdData[3], 32'hA1);
    readBurst(32'h108, 4'd3, 3'd2, 2'b10, 4'd2, 1'b0);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("wrapRd%0d", i), rdData[i], 32'hA0 + 32'(i));

    // Byte strobes over a zeroed word
    wrData[0] = 32'h0;
    writeBurst(32'h0, 4'd0, 2'b01, 4'hF, 4'd0, 4'd0, 0);
    wrData[0] = 32'hAABBCCDD;
    writeBurst(32'h0, 4'd0, 2'b01, 4'b0101, 4'd0, 4'd0, 0);
    readBurst(32'h0, 4'd0, 3'd2, 2'b01, 4'd0, 1'b0);
    checkOutput("strbData", rdData[0], 32'h00BB00DD);

    // Out-of-range read and write at DEPTH*4
    readBurst(32'h1000, 4'd0, 3'd2, 2'b01, 4'd4, 1'b0);
    checkOutput("decRdata", rdData[0], 32'd0);
    checkOutput("decRresp", 32'(rdResp[0]), 32'd3);
    wrData[0] = 32'hDEADBEEF;
    writeBurst(32'h1000, 4'd0, 2'b01, 4'hF, 4'd4, 4'd4, 0);
    checkOutput("decBresp", 32'(gotBresp), 32'd3);
    readBurst(32'h0, 4'd0, 3'd2, 2'b01, 4'd0, 1'b0);
    checkOutput("decNoAlias", rdData[0], 32'h00BB00DD);

    // len=7 read with rready toggling
    for (int i = 0; i < 8; i++) wrData[i] = 32'hC0DE0000 + 32'(i);
    writeBurst(32'h200, 4'd7, 2'b01, 4'hF, 4'd6, 4'd6, 7);
    readBurst(32'h200, 4'd7, 3'd2, 2'b01, 4'd7, 1'b1);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("toggleRd%0d", i), rdData[i], 32'hC0DE0000 + 32'(i));
    checkOutput("toggleLast", 32'(rdLast[7]), 32'd1);

    // Slave errors: wid mismatch, reserved burst, bad wrap length, oversize
    wrData[0] = 32'h12345678;
    writeBurst(32'h300, 4'd0, 2'b01, 4'hF, 4'd3, 4'd4, 0);
    checkOutput("widBresp", 32'(gotBresp), 32'd2);
    readBurst(32'h200, 4'd0, 3'd2, 2'b11, 4'd1, 1'b0);
    checkOutput("rsvdRresp", 32'(rdResp[0]), 32'd2);
    readBurst(32'h200, 4'd2, 3'd2, 2'b10, 4'd1, 1'b0);
    checkOutput("wrapLenRresp", 32'(rdResp[0]), 32'd2);
    readBurst(32'h200, 4'd0, 3'd3, 2'b01, 4'd1, 1'b0);
    checkOutput("sizeRresp", 32'(rdResp[0]), 32'd2);

    // wlast on beat 2 of 4
    for (int i = 0; i < 4; i++) wrData[i] = 32'h5A000000 + 32'(i);
    writeBurst(32'h300, 4'd3, 2'b01, 4'hF, 4'd2, 4'd2, 1);
`ifdef AXI_SLAVE_MEM_LAST_CHK_EN
    checkOutput("earlyLastBresp", 32'(gotBresp), 32'd2);
`else
    checkOutput("earlyLastBresp", 32'(gotBresp), 32'd0);
`endif

    // Reset pulse in the middle of a read
    araddr = 32'h200; arlen = 4'd7; arsize = 3'd2; arburst = 2'b01; arid = 4'd3; arvalid = 1'b1;
    rready = 1'b1;
    @(posedge aclk); #1;
    arvalid = 1'b0;
    @(posedge aclk); #1;
    checkOutput("midReadValid", 32'(rvalid), 32'd1);
    aresetn = 1'b0;
    #1;
    checkOutput("rstRvalidAsync", 32'(rvalid), 32'd0);
    checkOutput("rstArreadyAsync", 32'(arready), 32'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1; rready = 1'b0;
    @(posedge aclk); #1;
    checkOutput("arreadyAfterRst", 32'(arready), 32'd1);
    checkOutput("rvalidAfterRst", 32'(rvalid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/axi_slave_mem.md
# axi_slave_mem

Synthesisable, parametrised AXI3 slave memory: the next-generation slave model for the VIP bench, replacing the behavioural responder. It supports FIXED/INCR/WRAP bursts, byte strobes, configurable data/ID width and depth, and proper backpressure on every channel. It provides concurrent independent read and write engines with one outstanding transaction each, and sits behind the AXI master VIP as the default memory target.

## Interface
- DATA_W, 32, data bus width in bits (32/64/128)
- ID_W, 4, width of all ID fields
- DEPTH, 1024, memory size in DATA_W-bit words (power of two)
- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- awid/awaddr/awlen/awsize/awburst/awvalid  in  ID_W/32/4/3/2/1  write address channel
- awready  out  1
- wid/wdata/wstrb/wlast/wvalid  in  ID_W/DATA_W/DATA_W/8/1/1  write data channel
- wready  out  1
- bid/bresp/bvalid  out  ID_W/2/1; bready  in  1
- arid/araddr/arlen/arsize/arburst/arvalid  in  ID_W/32/4/3/2/1; arready  out  1
- rid/rdata/rresp/rlast/rvalid  out  ID_W/DATA_W/2/1/1; rready  in  1
- awlock/awcache/awprot and ar equivalents: accepted, ignored.

## Operation
- Write FSM: W_IDLE (awready=1) -> AW handshake latches id/addr/len/size/burst -> W_DATA (wready=1) -> each wvalid&&wready beat writes memory bytes where wstrb=1 -> after beat awlen+1 -> W_RESP (bvalid=1, bid=latched awid) -> bvalid&&bready -> W_IDLE.
- Read FSM: R_IDLE (arready=1) -> AR handshake -> R_DATA (rvalid=1) for arlen+1 beats, rlast on the final one -> R_IDLE after last rvalid&&rready.
- Address generation per beat: FIXED keeps addr; INCR adds 1<<size; WRAP adds 1<<size within a boundary of (len+1)<<size, aligned down. Word index = addr[log2(DEPTH)+log2(DATA_W/8)-1 : log2(DATA_W/8)].
- Responses (worst wins, per burst): DECERR (2'b11) if any beat address >= DEPTH*DATA_W/8; for such a beat the write is dropped and rdata=0. SLVERR (2'b10) if size > log2(DATA_W/8), WRAP len not in {1,3,7,15}, burst=2'b11, or wid != latched awid. Otherwise OKAY. rresp is reported per beat.
- Memory contents are not reset.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, bid=0, bresp=0, arready=0, rvalid=0, rlast=0, rid=0, rdata=0, rresp=0. awready and arready rise on the first aclk edge after aresetn deasserts.
- Write: wready is asserted the cycle after the AW handshake. bvalid is asserted the cycle after the last W beat. Back-to-back AW is accepted the cycle after the B handshake.
- Read: the first rvalid appears 1 cycle after the AR handshake (registered RAM read). Next beat follows the cycle after each rvalid&&rready, giving full throughput under continuous rready. rdata/rresp/rlast/rid hold stable while rvalid&&!rready.
- Same-cycle read and write to the same word: the read returns the old data.
- Reset mid-burst: both FSMs return to IDLE immediately, and all valids drop asynchronously. Partially written data stays.

## Configuration
- AXI_SLAVE_MEM_LAST_CHK_EN defined:
  - wlast asserted on any beat other than beat awlen+1, or missing on that beat, forces SLVERR.
  - The burst still ends by beat count.
- Not defined: wlast is ignored and the burst ends purely by count.

## Structure
- axi_slave_mem_pkg holds:
  - burst_t (FIXED/INCR/WRAP/RSVD) and resp_t (OKAY/EXOKAY/SLVERR/DECERR)
  - wstate_t and rstate_t
  - next_addr() function
- Sub-module axi_slave_mem_addr_gen: computes the next beat address from addr/size/len/burst. It is instantiated once per FSM.

## Test plan
- INCR write len=3 at 0x100 with data 0x11..0x44, then read back -> rdata 0x11,0x22,0x33,0x44, rlast on beat 4, bresp=rresp=OKAY.
- WRAP len=3 at 0x108 with DATA_W=32 -> write addresses 0x108,0x10C,0x100,0x104; readback matches.
- Write 0xAABBCCDD with wstrb=4'b0101 over 0x00000000 -> read gives 0x00BB00DD.
- Read at DEPTH*4 with DEPTH=1024 (0x1000) -> rdata=0, rresp=DECERR. Write at the same address -> bresp=DECERR and memory is unchanged.
- Read len=7 with rready toggling every other cycle -> 8 beats, rdata stable during stalls, no lost or duplicate beats.
- With AXI_SLAVE_MEM_LAST_CHK_EN, write len=3 with wlast on beat 2 -> bresp=SLVERR after beat 4. aresetn pulse mid-read -> rvalid low immediately and arready=1 after release.
